// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-back entry record.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] REG_PC = 4'd15;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_wb_fwd_match.sv
// Newest-first search of the pending write-back entries for one read address.
module reg_wb_fwd_match
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DATA_W = REG_DATA_W
) (
    input  logic [ADDR_W-1:0]         entry_addr [DEPTH],
    input  logic [DATA_W-1:0]         entry_data [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]  head,
    input  logic [$clog2(DEPTH):0]    count,
    input  logic [ADDR_W-1:0]         r_addr,
    output logic                      hit,
    output logic [DATA_W-1:0]         data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] idx;

    // Walk oldest to newest so a later match overrides an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entry_addr[idx] == r_addr)) begin
                hit  = 1'b1;
                data = entry_data[idx];
            end
        end
    end

endmodule

// File: rtl/reg_wb_queue.sv
// Write-back queue feeding the register file write port, one retirement per cycle.
// Operand forwarding from pending entries is built only when REG_WB_QUEUE_BYPASS_EN is defined.
module reg_wb_queue
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DATA_W = REG_DATA_W
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ready,
    input  logic              wb_hold,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic              Write_Reg,
    input  logic [ADDR_W-1:0] R_Addr_A,
    input  logic [ADDR_W-1:0] R_Addr_B,
    input  logic [ADDR_W-1:0] R_Addr_C,
    output logic              Fwd_Hit_A,
    output logic              Fwd_Hit_B,
    output logic              Fwd_Hit_C,
    output logic [DATA_W-1:0] Fwd_Data_A,
    output logic [DATA_W-1:0] Fwd_Data_B,
    output logic [DATA_W-1:0] Fwd_Data_C
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    logic push;
    logic pop;

    assign wb_ready  = (count_q != CNT_W'(DEPTH));
    assign Write_Reg = (count_q != '0) && !wb_hold;
    assign W_Addr    = addr_q[head_q];
    assign W_Data    = data_q[head_q];

    assign push = wb_valid && wb_ready;
    assign pop  = Write_Reg;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                addr_q[tail_q] <= wb_addr;
                data_q[tail_q] <= wb_data;
                tail_q         <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef REG_WB_QUEUE_BYPASS_EN
    reg_wb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd_a (
        .entry_addr (addr_q),
        .entry_data (data_q),
        .head       (head_q),
        .count      (count_q),
        .r_addr     (R_Addr_A),
        .hit        (Fwd_Hit_A),
        .data       (Fwd_Data_A)
    );

    reg_wb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd_b (
        .entry_addr (addr_q),
        .entry_data (data_q),
        .head       (head_q),
        .count      (count_q),
        .r_addr     (R_Addr_B),
        .hit        (Fwd_Hit_B),
        .data       (Fwd_Data_B)
    );

    reg_wb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd_c (
        .entry_addr (addr_q),
        .entry_data (data_q),
        .head       (head_q),
        .count      (count_q),
        .r_addr     (R_Addr_C),
        .hit        (Fwd_Hit_C),
        .data       (Fwd_Data_C)
    );
`else
    // Read addresses are only consumed by the forwarding search.
    logic unused_raddr;
    assign unused_raddr = ^{R_Addr_A, R_Addr_B, R_Addr_C};

    assign Fwd_Hit_A  = 1'b0;
    assign Fwd_Hit_B  = 1'b0;
    assign Fwd_Hit_C  = 1'b0;
    assign Fwd_Data_A = '0;
    assign Fwd_Data_B = '0;
    assign Fwd_Data_C = '0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Self-checking bench for reg_wb_queue: vector table, corner sequences and a queue-model random run.
module tb_reg_wb_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        Rst;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        wb_hold;
    logic [3:0]  W_Addr;
    logic [31:0] W_Data;
    logic        Write_Reg;
    logic [3:0]  R_Addr_A, R_Addr_B, R_Addr_C;
    logic        Fwd_Hit_A, Fwd_Hit_B, Fwd_Hit_C;
    logic [31:0] Fwd_Data_A, Fwd_Data_B, Fwd_Data_C;

    reg_wb_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (4),
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .Rst        (Rst),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_ready   (wb_ready),
        .wb_hold    (wb_hold),
        .W_Addr     (W_Addr),
        .W_Data     (W_Data),
        .Write_Reg  (Write_Reg),
        .R_Addr_A   (R_Addr_A),
        .R_Addr_B   (R_Addr_B),
        .R_Addr_C   (R_Addr_C),
        .Fwd_Hit_A  (Fwd_Hit_A),
        .Fwd_Hit_B  (Fwd_Hit_B),
        .Fwd_Hit_C  (Fwd_Hit_C),
        .Fwd_Data_A (Fwd_Data_A),
        .Fwd_Data_B (Fwd_Data_B),
        .Fwd_Data_C (Fwd_Data_C)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        valid;
        logic [3:0]  addr;
        logic [31:0] data;
        logic        exp_wr;
        logic [3:0]  exp_addr;
        logic [31:0] exp_data;
        logic        exp_ready;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    ent_t        mq [$];
    logic [31:0] rf_exp [16] = '{default: '0};
    logic [31:0] rf_dut [16] = '{default: '0};
    int          wr_count = 0;

    // Register file as seen through the DUT write port.
    always @(posedge clk) begin
        if (Write_Reg) begin
            rf_dut[W_Addr] <= W_Data;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_fwd(input logic [3:0] ra, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
`ifdef REG_WB_QUEUE_BYPASS_EN
        foreach (mq[i]) begin
            if (mq[i].addr == ra) begin
                hit = 1'b1;
                d   = mq[i].data;
            end
        end
`endif
    endtask

    // Check outputs mid-cycle against the queue model, then advance one clock.
    task automatic step();
        logic        exp_ready, exp_wr, h;
        logic        do_push;
        logic [31:0] d;
        @(negedge clk);
        exp_ready = (mq.size() != DEPTH);
        exp_wr    = (mq.size() != 0) && !wb_hold && !Rst;
        chk("wb_ready", wb_ready, exp_ready);
        chk("write_reg", Write_Reg, exp_wr);
        if (exp_wr) begin
            chk("w_addr", W_Addr, mq[0].addr);
            chk("w_data", W_Data, mq[0].data);
        end
        model_fwd(R_Addr_A, h, d);
        chk("fwd_hit_a", Fwd_Hit_A, h);
        chk("fwd_data_a", Fwd_Data_A, d);
        model_fwd(R_Addr_B, h, d);
        chk("fwd_hit_b", Fwd_Hit_B, h);
        chk("fwd_data_b", Fwd_Data_B, d);
        model_fwd(R_Addr_C, h, d);
        chk("fwd_hit_c", Fwd_Hit_C, h);
        chk("fwd_data_c", Fwd_Data_C, d);
        do_push = wb_valid && exp_ready && !Rst;
        @(posedge clk);
        if (exp_wr) begin
            rf_exp[mq[0].addr] = mq[0].data;
            void'(mq.pop_front());
        end
        if (do_push) mq.push_back('{addr: wb_addr, data: wb_data});
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [31:0] d, input logic h);
        wb_valid = v;
        wb_addr  = a;
        wb_data  = d;
        wb_hold  = h;
    endtask

    vec_t vecs [5];

    initial begin
        Rst = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 1'b0);
        R_Addr_A = 4'd0;
        R_Addr_B = 4'd0;
        R_Addr_C = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_write_reg", Write_Reg, 1'b0);
        chk("reset_ready", wb_ready, 1'b1);
        Rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            #2;
            chk("idle_w_addr", W_Addr, 4'd0);
            chk("idle_w_data", W_Data, 32'd0);
            step();
        end

        // Three back-to-back pushes, drained one cycle later.
        vecs[0] = '{1'b1, 4'd1, 32'hAC963A55, 1'b0, 4'd0, 32'd0,         1'b1};
        vecs[1] = '{1'b1, 4'd2, 32'h11111111, 1'b1, 4'd1, 32'hAC963A55, 1'b1};
        vecs[2] = '{1'b1, 4'd3, 32'hFFFFFFFF, 1'b1, 4'd2, 32'h11111111, 1'b1};
        vecs[3] = '{1'b0, 4'd0, 32'd0,        1'b1, 4'd3, 32'hFFFFFFFF, 1'b1};
        vecs[4] = '{1'b0, 4'd0, 32'd0,        1'b0, 4'd0, 32'd0,         1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].valid, vecs[i].addr, vecs[i].data, 1'b0);
            #2;
            chk("vec_write_reg", Write_Reg, vecs[i].exp_wr);
            chk("vec_ready", wb_ready, vecs[i].exp_ready);
            if (vecs[i].exp_wr) begin
                chk("vec_w_addr", W_Addr, vecs[i].exp_addr);
                chk("vec_w_data", W_Data, vecs[i].exp_data);
            end
            step();
        end
        chk("rf_r1", rf_dut[1], 32'hAC963A55);
        chk("rf_r2", rf_dut[2], 32'h11111111);
        chk("rf_r3", rf_dut[3], 32'hFFFFFFFF);

        // Hold draining, fill past capacity, then release.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'(6 + i), $urandom, 1'b1);
            step();
        end
        #2;
        chk("full_ready", wb_ready, 1'b0);
        drive(1'b1, 4'd10, 32'h5A5A0010, 1'b1);
        step();
        step();
        chk("held_ready", wb_ready, 1'b0);
        wb_hold = 1'b0;
        step();
        #2;
        chk("ready_after_pop", wb_ready, 1'b1);
        step();
        drive(1'b0, 4'd0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        chk("hold_drained", Write_Reg, 1'b0);
        chk("rf_r10", rf_dut[10], 32'h5A5A0010);

`ifdef REG_WB_QUEUE_BYPASS_EN
        // Newest pending write wins for a duplicated address.
        drive(1'b1, 4'd4, 32'h1, 1'b1);
        step();
        drive(1'b1, 4'd4, 32'h2, 1'b1);
        step();
        drive(1'b0, 4'd0, 32'd0, 1'b1);
        R_Addr_A = 4'd4;
        R_Addr_B = 4'd5;
        #2;
        chk("byp_hit_a", Fwd_Hit_A, 1'b1);
        chk("byp_data_a", Fwd_Data_A, 32'h2);
        chk("byp_hit_b", Fwd_Hit_B, 1'b0);
        wb_hold = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("rf_r4", rf_dut[4], 32'h2);
`endif

        // Full-throughput push/pop pairs across pointer wrap.
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 4'(i + 5), $urandom, 1'b0);
            step();
            chk("wrap_depth", mq.size(), 1);
        end
        drive(1'b0, 4'd0, 32'd0, 1'b0);
        step();
        step();
        for (int r = 0; r < 16; r++) chk("wrap_rf", rf_dut[r], rf_exp[r]);

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 99) < 60), 4'($urandom), $urandom,
                  1'($urandom_range(0, 99) < 30));
            R_Addr_A = 4'($urandom);
            R_Addr_B = 4'($urandom);
            R_Addr_C = 4'($urandom_range(0, 3));
            step();
        end
        drive(1'b0, 4'd0, 32'd0, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) step();
        for (int r = 0; r < 16; r++) chk("rand_rf", rf_dut[r], rf_exp[r]);

        // Reset with three pending writes discards them.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(12 + i), 32'hDEAD0000 + 32'(i), 1'b1);
            step();
        end
        drive(1'b0, 4'd0, 32'd0, 1'b0);
        #1;
        Rst = 1'b1;
        #1;
        chk("rst_write_reg", Write_Reg, 1'b0);
        chk("rst_ready", wb_ready, 1'b1);
        chk("rst_w_addr", W_Addr, 4'd0);
        chk("rst_w_data", W_Data, 32'd0);
        mq.delete();
        begin
            int wc;
            wc = wr_count;
            step();
            Rst = 1'b0;
            for (int i = 0; i < 6; i++) step();
            chk("rst_no_writes", wr_count, wc);
        end
        for (int r = 0; r < 16; r++) chk("rst_rf", rf_dut[r], rf_exp[r]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
